// File: rtl/a2g_rst_pkg.sv
// Shared definitions for the datapath reset sequencer: FSM encoding and
// the bit layout of the control and status registers.
package a2g_rst_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_ASSERT = 3'd1,
    ST_STEP   = 3'd2,
    ST_WAIT   = 3'd3,
    ST_DONE   = 3'd4,
    ST_ERROR  = 3'd5
  } seq_state_e;

  localparam int DEF_TIMEOUT_CYC = 1024;

  localparam int CTRL_START_BIT = 0;
  localparam int CTRL_ABORT_BIT = 1;
  localparam int CTRL_HOLD_LSB  = 8;
  localparam int CTRL_MASK_LSB  = 16;

  localparam int STAT_BUSY_BIT  = 0;
  localparam int STAT_DONE_BIT  = 1;
  localparam int STAT_ERROR_BIT = 2;
  localparam int STAT_FAIL_LSB  = 4;
  localparam int STAT_RST_LSB   = 8;
  localparam int STAT_CNT_LSB   = 16;

endpackage

// File: rtl/a2g_rst_sequencer_rise_detect.sv
// Rising-edge detector for the software start bit. A level that is already
// high when reset releases must fall once before it can trigger.
module rise_detect (
  input  logic clk,
  input  logic rst_n,
  input  logic level,
  output logic pulse
);

  logic level_q;
  logic armed;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      level_q <= 1'b0;
      armed   <= 1'b0;
    end else begin
      level_q <= level;
      if (!level) armed <= 1'b1;
    end
  end

  assign pulse = level & ~level_q & armed;

endmodule

// File: rtl/a2g_rst_sequencer.sv
// Releases datapath stage resets one at a time in index order, waiting for
// each masked stage to report ready before moving on.
module a2g_rst_sequencer
  import a2g_rst_pkg::*;
#(
  parameter int N_STAGES    = 4,
  parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
  input  logic                user_clk,
  input  logic                user_rst_n,
  input  logic [31:0]         ctrl_word,
  input  logic [N_STAGES-1:0] stage_ready,
  output logic [N_STAGES-1:0] stage_rst,
  output logic [31:0]         status_word
);

  localparam int IW = $clog2(N_STAGES);
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [IW-1:0] LAST_IDX = IW'(N_STAGES - 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYC - 1);

  seq_state_e          state;
  logic [IW-1:0]       idx;
  logic [7:0]          hold_q;
  logic [7:0]          hold_cnt;
  logic [N_STAGES-1:0] mask_q;
  logic [TW-1:0]       tmo_cnt;
  logic                busy;
  logic                done;
  logic                error;
  logic [2:0]          fail_idx;
  logic [15:0]         seq_cnt;

  logic                start_pulse;
  logic                abort;
  logic [N_STAGES-1:0] eff_mask;
  logic                unused_ctrl;

  rise_detect u_start_edge (
    .clk   (user_clk),
    .rst_n (user_rst_n),
    .level (ctrl_word[CTRL_START_BIT]),
    .pulse (start_pulse)
  );

  assign abort       = ctrl_word[CTRL_ABORT_BIT];
  assign eff_mask    = ctrl_word[CTRL_MASK_LSB +: N_STAGES];
  assign unused_ctrl = ^{ctrl_word[31:24], ctrl_word[23:16], ctrl_word[7:2]};

  always_ff @(posedge user_clk or negedge user_rst_n) begin
    if (!user_rst_n) begin
      state     <= ST_IDLE;
      idx       <= '0;
      hold_q    <= '0;
      hold_cnt  <= '0;
      mask_q    <= '0;
      tmo_cnt   <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      error     <= 1'b0;
      fail_idx  <= '0;
      seq_cnt   <= '0;
      stage_rst <= '1;
    end else if (abort) begin
      state     <= ST_IDLE;
      stage_rst <= '1;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      case (state)
        ST_IDLE, ST_DONE, ST_ERROR: begin
          if (start_pulse) begin
            state     <= ST_ASSERT;
            busy      <= 1'b1;
            done      <= 1'b0;
            error     <= 1'b0;
            fail_idx  <= '0;
            mask_q    <= eff_mask;
            hold_q    <= ctrl_word[CTRL_HOLD_LSB +: 8];
            hold_cnt  <= '0;
            stage_rst <= stage_rst | eff_mask;
          end
        end

        ST_ASSERT: begin
          if (hold_cnt == hold_q) begin
            state <= ST_STEP;
            idx   <= '0;
          end else begin
            hold_cnt <= hold_cnt + 8'd1;
          end
        end

        ST_STEP: begin
          if (mask_q[idx]) begin
            stage_rst[idx] <= 1'b0;
            tmo_cnt        <= '0;
            state          <= ST_WAIT;
          end else if (idx == LAST_IDX) begin
            state <= ST_DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
            if (seq_cnt != 16'hFFFF) seq_cnt <= seq_cnt + 16'd1;
          end else begin
            idx <= idx + 1'b1;
          end
        end

        // Ready is checked before the timeout so a late lock still wins.
        ST_WAIT: begin
          if (stage_ready[idx]) begin
            if (idx == LAST_IDX) begin
              state <= ST_DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
              if (seq_cnt != 16'hFFFF) seq_cnt <= seq_cnt + 16'd1;
            end else begin
              idx   <= idx + 1'b1;
              state <= ST_STEP;
            end
          end else if (tmo_cnt == TMO_LAST) begin
            // A stage that never locked goes back into reset with the rest.
            state          <= ST_ERROR;
            busy           <= 1'b0;
            error          <= 1'b1;
            fail_idx       <= 3'(idx);
            stage_rst[idx] <= 1'b1;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

  always_comb begin
    status_word                            = '0;
    status_word[STAT_BUSY_BIT]             = busy;
    status_word[STAT_DONE_BIT]             = done;
    status_word[STAT_ERROR_BIT]            = error;
    status_word[STAT_FAIL_LSB +: 3]        = fail_idx;
    status_word[STAT_RST_LSB +: N_STAGES]  = stage_rst;
    status_word[STAT_CNT_LSB +: 16]        = seq_cnt;
  end

endmodule

// File: tb/tb_a2g_rst_sequencer.sv
// Scoreboard bench for the reset sequencer: each sequence is planned as a
// timeline of edges, expected outputs are queued and a monitor compares them.
module tb_a2g_rst_sequencer;

  localparam int NS  = 4;
  localparam int TMO = 16;
  localparam int EF_NONE = 0, EF_REL = 1, EF_DONE = 2, EF_ERR = 3;
  localparam int IK_NONE = 0, IK_ABORT = 1, IK_RESET = 2;

  logic          user_clk;
  logic          user_rst_n;
  logic [31:0]   ctrl_word;
  logic [NS-1:0] stage_ready;
  logic [NS-1:0] stage_rst;
  logic [31:0]   status_word;

  a2g_rst_sequencer #(.N_STAGES(NS), .TIMEOUT_CYC(TMO)) dut (
    .user_clk    (user_clk),
    .user_rst_n  (user_rst_n),
    .ctrl_word   (ctrl_word),
    .stage_ready (stage_ready),
    .stage_rst   (stage_rst),
    .status_word (status_word)
  );

  initial user_clk = 1'b0;
  always #5 user_clk = ~user_clk;

  typedef struct { int tag; logic [NS+31:0] val; string nm; } exp_t;
  typedef struct { int stage; bit rdy; int eff; int idx; } plan_t;

  exp_t sb[$];
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  bit   stim_done = 1'b0;
  bit   final_chk = 1'b0;

  // Abstract model of what software sees
  logic [NS-1:0] m_rst;
  bit            m_busy, m_done, m_err;
  logic [2:0]    m_fail;
  logic [15:0]   m_cnt;

  always @(posedge user_clk) cyc <= cyc + 1;

  function automatic logic [31:0] m_status();
    logic [31:0] s;
    s         = '0;
    s[0]      = m_busy;
    s[1]      = m_done;
    s[2]      = m_err;
    s[6:4]    = m_fail;
    s[8+:NS]  = m_rst;
    s[31:16]  = m_cnt;
    return s;
  endfunction

  function automatic logic [NS-1:0] with_bit(input logic [NS-1:0] v, input int i, input bit b);
    logic [NS-1:0] m;
    m = NS'(1) << i;
    return b ? (v | m) : (v & ~m);
  endfunction

  always @(negedge user_clk) begin
    exp_t e;
    while (sb.size() > 0 && sb[0].tag < cyc) begin
      e = sb.pop_front();
      checks++; errors++;
      $display("FAIL %s: sample for cycle %0d skipped (now %0d), want it compared", e.nm, e.tag, cyc);
    end
    if (sb.size() > 0 && sb[0].tag == cyc) begin
      e = sb.pop_front();
      checks++;
      if ({stage_rst, status_word} !== e.val) begin
        errors++;
        $display("FAIL %s @cyc %0d: got rst=%b status=%h, want rst=%b status=%h",
                 e.nm, cyc, stage_rst, status_word, e.val[NS+31:32], e.val[31:0]);
      end
    end
    if (stim_done && !final_chk) begin
      final_chk = 1'b1;
      checks++;
      if (sb.size() != 0) begin
        errors++;
        $display("FAIL drain: %0d expectations pending, want 0", sb.size());
      end
    end
  end

  task automatic drive(input logic [31:0] c, input logic [NS-1:0] r, input string nm);
    ctrl_word   = c;
    stage_ready = r;
    sb.push_back('{cyc + 1, {m_rst, m_status()}, nm});
    @(posedge user_clk); #1;
  endtask

  task automatic idle(input int n, input bit ab);
    logic [31:0] c;
    for (int i = 0; i < n; i++) begin
      c = $urandom & 32'hFFFF_FF00;
      if (ab && $urandom_range(0, 4) == 0) begin
        c[1] = 1'b1; m_rst = '1; m_busy = 0; m_done = 0;
      end
      drive(c, NS'($urandom), "idle");
    end
  endtask

  task automatic do_reset(input string nm);
    user_rst_n = 1'b0;
    m_rst = '1; m_busy = 0; m_done = 0; m_err = 0; m_fail = '0; m_cnt = '0;
    if (sb.size() > 0) void'(sb.pop_back());
    sb.push_back('{cyc, {m_rst, m_status()}, {nm, "_rst_async"}});
    repeat (2) drive(32'h1, NS'($urandom), {nm, "_in_rst"});
    user_rst_n = 1'b1;
    repeat (3) drive(32'h1, NS'($urandom), {nm, "_start_held"});
    drive(32'h0, NS'($urandom), {nm, "_start_low"});
  endtask

  // k[i]: WAIT cycle (1-based) in which stage i reports ready; >TMO never does.
  task automatic run_seq(input logic [7:0] mf, input logic [7:0] hold, input int k[NS],
                         input int ik, input int ie, input bit istart, input int sbe,
                         input string nm);
    plan_t         plan[$];
    plan_t         p;
    logic [31:0]   base, c;
    logic [NS-1:0] r, em;
    bit            last;
    base = {8'h00, mf, hold, 8'h00};
    em   = mf[NS-1:0];
    for (int h = 0; h <= int'(hold); h++) plan.push_back('{-1, 1'b0, EF_NONE, 0});
    for (int i = 0; i < NS; i++) begin
      last = (i == NS - 1);
      if (((em >> i) & NS'(1)) == '0) begin
        plan.push_back('{-1, 1'b0, last ? EF_DONE : EF_NONE, i});
      end else begin
        plan.push_back('{-1, 1'b0, EF_REL, i});
        if (k[i] <= TMO) begin
          for (int j = 1; j < k[i]; j++) plan.push_back('{i, 1'b0, EF_NONE, i});
          plan.push_back('{i, 1'b1, last ? EF_DONE : EF_NONE, i});
        end else begin
          for (int j = 1; j < TMO; j++) plan.push_back('{i, 1'b0, EF_NONE, i});
          plan.push_back('{i, 1'b0, EF_ERR, i});
          break;
        end
      end
    end

    m_rst = m_rst | em; m_busy = 1; m_done = 0; m_err = 0; m_fail = '0;
    drive(base | 32'h1, NS'($urandom), {nm, "_start"});
    for (int e = 0; e < plan.size(); e++) begin
      p = plan[e];
      c = base;
      r = NS'($urandom);
      if (p.stage >= 0) r = with_bit(r, p.stage, p.rdy);
      if (ik == IK_RESET && e == ie) begin
        do_reset(nm);
        return;
      end
      if (ik == IK_ABORT && e == ie) begin
        c[1] = 1'b1; c[0] = istart;
        m_rst = '1; m_busy = 0; m_done = 0;
        drive(c, r, {nm, "_abort"});
        drive(base, NS'($urandom), {nm, "_post_abort"});
        return;
      end
      if (e == sbe) c[0] = 1'b1;
      case (p.eff)
        EF_REL:  m_rst = with_bit(m_rst, p.idx, 1'b0);
        EF_DONE: begin
          m_busy = 0; m_done = 1;
          if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
        end
        EF_ERR: begin
          m_busy = 0; m_err = 1; m_fail = 3'(p.idx);
          m_rst = with_bit(m_rst, p.idx, 1'b1);
        end
        default: ;
      endcase
      drive(c, r, nm);
    end
    drive(base, NS'($urandom), {nm, "_tail"});
  endtask

  initial begin
    user_rst_n  = 1'b0;
    ctrl_word   = '0;
    stage_ready = '0;
    m_rst = '1; m_busy = 0; m_done = 0; m_err = 0; m_fail = '0; m_cnt = '0;
    repeat (2) @(posedge user_clk);
    #1;
    sb.push_back('{cyc, {m_rst, m_status()}, "reset_state"});
    drive(32'h0, '0, "reset_state");
    user_rst_n = 1'b1;
    idle(3, 1'b0);

    run_seq(8'h0F, 8'd3, '{1, 1, 1, 1}, IK_NONE, -1, 1'b0, -1, "seq_full");
    idle(2, 1'b0);
    run_seq(8'hF5, 8'd0, '{1, 1, 1, 1}, IK_NONE, -1, 1'b0, -1, "seq_mask5");
    idle(2, 1'b1);
    run_seq(8'h0F, 8'd2, '{1, 1, 99, 1}, IK_NONE, -1, 1'b0, -1, "seq_timeout");
    idle(2, 1'b0);
    run_seq(8'h0F, 8'd2, '{1, 5, 1, 1}, IK_ABORT, 7, 1'b1, -1, "seq_abort_wait1");
    idle(2, 1'b0);
    run_seq(8'h0F, 8'd1, '{1, TMO, 2, 3}, IK_NONE, -1, 1'b0, 4, "seq_ready_at_tmo");
    run_seq(8'hF0, 8'd5, '{1, 1, 1, 1}, IK_NONE, -1, 1'b0, 3, "seq_zero_mask");
    idle(1, 1'b0);
    run_seq(8'h0F, 8'd6, '{1, 1, 1, 1}, IK_RESET, 3, 1'b0, -1, "seq_rst_assert");
    run_seq(8'h0F, 8'd0, '{2, 1, 3, 1}, IK_NONE, -1, 1'b0, -1, "seq_after_rst");

    for (int s = 0; s < 24; s++) begin
      int         kk[NS];
      int         ik, ie, sbe;
      logic [7:0] mf, hd;
      mf = 8'($urandom);
      hd = 8'($urandom_range(0, 10));
      foreach (kk[j]) kk[j] = $urandom_range(1, TMO + 2);
      ik = IK_NONE; ie = -1; sbe = -1;
      case ($urandom_range(0, 7))
        0, 1: begin ik = IK_ABORT; ie = $urandom_range(0, 40); end
        2:    begin ik = IK_RESET; ie = $urandom_range(0, int'(hd)); end
        default: ;
      endcase
      if ($urandom_range(0, 1) == 1) sbe = $urandom_range(1, 30);
      run_seq(mf, hd, kk, ik, ie, 1'($urandom_range(0, 1)), sbe, "rand");
      idle($urandom_range(1, 3), 1'b1);
    end

    idle(2, 1'b0);
    stim_done = 1'b1;
    repeat (3) @(negedge user_clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/a2g_rst_sequencer.md
A2G_RST_SEQUENCER -- requirements
Module: a2g_rst_sequencer

Interface
REQ-001 SHALL have parameter N_STAGES, default 4: number of sequenced datapath stages (2..8).
REQ-002 SHALL have parameter TIMEOUT_CYC, default 1024: maximum cycles to wait for a stage's ready.
REQ-003 SHALL have port user_clk, input, 1: the single clock for all logic.
REQ-004 SHALL have port user_rst_n, input, 1: asynchronous, active-low reset.
REQ-005 SHALL have port ctrl_word, input, 32: control register value, already in the user_clk domain.
  - [0] start, rising-edge triggered.
  - [1] abort, level.
  - [15:8] hold length.
  - [23:16] stage mask; bits at or above N_STAGES are ignored.
REQ-006 SHALL have port stage_ready, input, N_STAGES: per-stage ready/lock indication.
REQ-007 SHALL have port stage_rst, output, N_STAGES: active-high reset to each datapath stage.
REQ-008 SHALL have port status_word, output, 32: read-back value for the status register.
  - [0] busy; [1] done; [2] error.
  - [6:4] failing stage index.
  - [15:8] stage_rst mirror, zero-extended.
  - [31:16] completed-sequence count.

Function
REQ-009 SHALL register ctrl_word[0] each cycle and form start_pulse = ctrl_word[0] AND NOT registered value.
REQ-010 SHALL implement FSM states IDLE, ASSERT, STEP, WAIT, DONE, ERROR.
REQ-011 SHALL move from IDLE, DONE or ERROR to ASSERT on start_pulse, clearing done, error and the fail index.
REQ-012 SHALL ignore start_pulse while in ASSERT, STEP or WAIT.
REQ-013 SHALL, in ASSERT:
  - drive stage_rst[i]=1 for every masked stage;
  - leave unmasked stages unchanged;
  - stay for hold+1 cycles (hold=0 gives 1 cycle, hold=255 gives 256 cycles);
  - then go to STEP with index 0.
REQ-014 SHALL, in STEP, spend exactly one cycle per index:
  - unmasked index: increment the index;
  - masked index: clear stage_rst[index] and go to WAIT.
REQ-015 SHALL go to DONE when the index reaches N_STAGES.
REQ-016 SHALL, in WAIT, clear the timeout counter on entry and increment it each cycle.
  - stage_ready[index]=1: index+1, return to STEP.
  - Counter reaches TIMEOUT_CYC-1 without ready: go to ERROR and latch the fail index.
  - Later masked stages remain in reset.
REQ-017 SHALL give ready priority when ready and timeout occur in the same cycle.
REQ-018 SHALL, on entry to DONE, set done=1 and increment the sequence count, saturating at 16'hFFFF.
REQ-019 SHALL drive busy=1 exactly while in ASSERT, STEP or WAIT.
REQ-020 SHALL, while abort=1 in any state:
  - go to IDLE on the next edge;
  - drive all stage_rst to 1 and clear busy and done;
  - let abort take priority over a simultaneous start_pulse.
REQ-021 SHALL treat a zero effective mask as a valid sequence: ASSERT, then N_STAGES STEP cycles, then DONE, with stage_rst unchanged.
REQ-022 SHALL register all outputs, with status_word reflecting state one cycle after each transition.

Reset
REQ-023 SHALL, while user_rst_n=0, asynchronously force:
  - stage_rst to all ones;
  - FSM to IDLE;
  - status_word to 0 except the stage_rst mirror;
  - edge register, counters and sequence count to 0.
REQ-024 SHALL treat reset asserted mid-sequence as an abort, with no partial release retained.
REQ-025 SHALL, after reset, keep stage_rst high until a sequence completes its STEP phase.

Structure
REQ-026 SHALL place the FSM state encoding, ctrl_word/status_word bit-field constants and the default TIMEOUT_CYC in a shared package a2g_rst_pkg.
REQ-027 SHALL implement the start edge detect as a single sub-module rise_detect, instantiated once; all other logic is flat.

Verification
REQ-028 SHALL cover: mask=0xF, hold=3, all ready one cycle after their release.
  - Expect ASSERT for 4 cycles, then stages released in order 0..3 at STEP/WAIT boundaries.
  - Expect done=1 and count=1.
REQ-029 SHALL cover: mask=0x5, hold=0.
  - Expect stage_rst[1] and stage_rst[3] to remain 1.
  - Expect indices 1 and 3 to pass in one cycle each.
  - Expect done=1.
REQ-030 SHALL cover: mask=0xF, stage_ready[2] stuck 0, TIMEOUT_CYC=16.
  - Expect ERROR 16 cycles after entering WAIT(2).
  - Expect fail index=2 and stage_rst=4'b1100.
REQ-031 SHALL cover: abort raised during WAIT(1), with start rising in the same cycle.
  - Expect IDLE next cycle, stage_rst=4'hF, busy=0.
REQ-032 SHALL cover: user_rst_n pulsed low during ASSERT.
  - Expect immediate stage_rst=4'hF and status_word=32'h00000F00.
  - Expect start held high through reset release not to trigger until it toggles.
REQ-033 SHALL cover: ready coincident with the final timeout cycle, and a start edge while busy.
  - Expect no ERROR.
  - Expect the second start to be ignored.
